scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_pkg.sv | 14 +
 rtl/decoder_3to8.sv | 14 +
 rtl/dwell_counter.sv | 32 +++
 rtl/scan_sequencer.sv | 127 ++++++++++++
 tb/tb_scan_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer.
//   state_t : sequencer FSM states (IDLE, RUN)
//   SEL_W   : width of the select output
//   SEL_MIN : lowest select value, used as the start for up scans and the terminal for down scans
//   SEL_MAX : highest select value, used as the start for down scans and the terminal for up scans
package scan_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_MIN = 3'd0;
  localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

endpackage

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder driven by the scan select.
//   a : binary select
//   y : one-hot output, y[a] = 1
module decoder_3to8 (
  input  logic [2:0] a,
  output logic [7:0] y
);

  always_comb begin
    y    = 8'd0;
    y[a] = 1'b1;
  end

endmodule

// File: rtl/dwell_counter.sv
// Dwell counter: counts cycles spent on the current select value.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (priority over en)
//   en       : count enable
//   limit    : latched dwell value to compare against
//   eq       : high when the count equals limit (the last cycle of a dwell)
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] limit,
  output logic               eq
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign eq = (count == limit);

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit select through 0..7 (up) or 7..0 (down),
// holding each value dwell+1 cycles, in one-shot or continuous mode.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a scan (sampled in IDLE, ignored in RUN)
//   stop     : abort a scan; also blocks a simultaneous start in IDLE
//   mode     : 0 one-shot, 1 continuous (latched at start)
//   dir      : 0 up, 1 down (latched at start)
//   dwell    : extra hold cycles per select value (latched at start)
//   sel      : registered select for the 3-to-8 decoder
//   active   : high while scanning
//   step     : pulse with each new sel value after the first
//   done     : pulse at the end of each pass
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               active,
  output logic               step,
  output logic               done
);

  state_t             state, state_n;
  logic [SEL_W-1:0]   sel_n;
  logic               active_n, step_n, done_n;
  logic               mode_l, mode_n;
  logic               dir_l, dir_n;
  logic [DWELL_W-1:0] dwell_l, dwell_n;
  logic               cnt_clr, cnt_en, cnt_eq;
  logic               at_term;

  dwell_counter #(.DWELL_W(DWELL_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (dwell_l),
    .eq    (cnt_eq)
  );

  assign at_term = (sel == (dir_l ? SEL_MIN : SEL_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= SEL_MIN;
      active  <= 1'b0;
      step    <= 1'b0;
      done    <= 1'b0;
      mode_l  <= 1'b0;
      dir_l   <= 1'b0;
      dwell_l <= '0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      active  <= active_n;
      step    <= step_n;
      done    <= done_n;
      mode_l  <= mode_n;
      dir_l   <= dir_n;
      dwell_l <= dwell_n;
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    active_n = active;
    step_n   = 1'b0;
    done_n   = 1'b0;
    mode_n   = mode_l;
    dir_n    = dir_l;
    dwell_n  = dwell_l;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    case (state)
      IDLE: begin
        active_n = 1'b0;
        // The counter is held clear in IDLE, so a new scan starts from zero.
        if (start && !stop) begin
          mode_n   = mode;
          dir_n    = dir;
          dwell_n  = dwell;
          sel_n    = dir ? SEL_MAX : SEL_MIN;
          state_n  = RUN;
          active_n = 1'b1;
        end
      end
      RUN: begin
        cnt_en  = 1'b1;
        cnt_clr = stop | cnt_eq;
        // stop outranks the terminal event, so an aborted pass never reports done.
        if (stop) begin
          state_n  = IDLE;
          active_n = 1'b0;
        end else if (cnt_eq) begin
          if (at_term) begin
            done_n = 1'b1;
            if (mode_l) begin
              sel_n  = dir_l ? SEL_MAX : SEL_MIN;
              step_n = 1'b1;
            end else begin
              state_n  = IDLE;
              active_n = 1'b0;
            end
          end else begin
            sel_n  = dir_l ? sel - 1'b1 : sel + 1'b1;
            step_n = 1'b1;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        active_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  logic       clk = 1'b0;
  bit         clk_run = 1'b1;
  logic       rst, start, stop, mode, dir;
  logic [3:0] dwell;
  logic [2:0] sel;
  logic       active, step, done;
  logic [7:0] y;
  int         total = 0;
  int         bad = 0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  scan_sequencer #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .dwell(dwell), .sel(sel), .active(active), .step(step), .done(done)
  );

  decoder_3to8 u_dec (.a(sel), .y(y));

  // Reference model: position in the scan is tracked as the number of cycles
  // t elapsed since the start edge; sel, step and done follow arithmetically.
  typedef struct packed {
    logic       run;
    logic [2:0] sel;
    logic       step;
    logic       done;
    int         t;
    logic       mode;
    logic       dir;
    int         per;
  } mstate_t;

  mstate_t m;
  logic [7:0] exp_y;
  assign exp_y = 8'd1 << m.sel;

  function automatic mstate_t model_next(mstate_t c, logic st, logic sp, logic md,
                                         logic dr, logic [3:0] dw);
    mstate_t n = c;
    int k;
    n.step = 1'b0;
    n.done = 1'b0;
    if (!c.run) begin
      if (st && !sp) begin
        n.run = 1'b1; n.mode = md; n.dir = dr; n.per = int'(dw) + 1; n.t = 0;
        n.sel = dr ? 3'd7 : 3'd0;
      end
    end else if (sp) begin
      n.run = 1'b0;
    end else begin
      n.t = c.t + 1;
      if (!c.mode && n.t == 8 * c.per) begin
        n.run  = 1'b0;
        n.done = 1'b1;
      end else begin
        k = (n.t / c.per) % 8;
        n.sel  = c.dir ? 3'(7 - k) : 3'(k);
        n.step = (n.t % c.per) == 0;
        n.done = (n.t % (8 * c.per)) == 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, start, stop, mode, dir, dwell);
  end

  task automatic test_reset();
    @(negedge clk);
    start = 1'b1; mode = 1'b1; dir = 1'b0; dwell = 4'($urandom_range(0, 3));
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    clk_run = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++; if (sel !== 3'b000) begin bad++; $display("FAIL reset_sel got=%b want=000", sel); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", active); end
    total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", step); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (y !== 8'b00000001) begin bad++; $display("FAIL reset_y got=%b want=00000001", y); end
    #3 rst = 1'b0;
    clk_run = 1'b1;
  endtask

  task automatic test_oneshot_up();
    int ac = 0, sc = 0, dc = 0;
    @(negedge clk);
    dwell = 4'd1; mode = 1'b0; dir = 1'b0; start = 1'b1; stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 22; c++) begin
      total++;
      if ({sel, active, step, done, y} !== {m.sel, m.run, m.step, m.done, exp_y}) begin
        bad++;
        $display("FAIL oneshot_model cyc=%0d got sel=%0d act=%b stp=%b dn=%b y=%b want sel=%0d act=%b stp=%b dn=%b y=%b",
                 c, sel, active, step, done, y, m.sel, m.run, m.step, m.done, exp_y);
      end
      if (active) begin
        total++;
        if (sel !== 3'(ac / 2)) begin bad++; $display("FAIL oneshot_seq idx=%0d got=%0d want=%0d", ac, sel, ac / 2); end
        ac++;
      end
      if (step) sc++;
      if (done) begin
        dc++;
        total++;
        if (active !== 1'b0 || ac != 16) begin bad++; $display("FAIL oneshot_done_edge got act=%b acnt=%0d want act=0 acnt=16", active, ac); end
      end
      @(negedge clk);
    end
    total++; if (ac != 16) begin bad++; $display("FAIL oneshot_active_len got=%0d want=16", ac); end
    total++; if (sc != 7) begin bad++; $display("FAIL oneshot_steps got=%0d want=7", sc); end
    total++; if (dc != 1) begin bad++; $display("FAIL oneshot_dones got=%0d want=1", dc); end
    total++; if (sel !== 3'd7) begin bad++; $display("FAIL oneshot_hold got=%0d want=7", sel); end
  endtask

  task automatic test_down_continuous();
    @(negedge clk);
    dwell = 4'd0; mode = 1'b1; dir = 1'b1; start = 1'b1; stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      total++;
      if ({sel, active, step, done, y} !== {m.sel, m.run, m.step, m.done, exp_y}) begin
        bad++;
        $display("FAIL downc_model k=%0d got sel=%0d act=%b stp=%b dn=%b want sel=%0d act=%b stp=%b dn=%b",
                 k, sel, active, step, done, m.sel, m.run, m.step, m.done);
      end
      total++;
      if (sel !== 3'(7 - k % 8) || active !== 1'b1 || step !== (k > 0) || done !== (k > 0 && k % 8 == 0)) begin
        bad++;
        $display("FAIL downc_seq k=%0d got sel=%0d act=%b stp=%b dn=%b want sel=%0d act=1 stp=%b dn=%b",
                 k, sel, active, step, done, 7 - k % 8, k > 0, k > 0 && k % 8 == 0);
      end
      // Latched settings must not follow these mid-run changes.
      mode = 1'($urandom); dir = 1'($urandom); dwell = 4'($urandom);
      start = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (active !== 1'b0 || done !== 1'b0 || step !== 1'b0) begin
      bad++; $display("FAIL downc_stop got act=%b dn=%b stp=%b want 0 0 0", active, done, step);
    end
  endtask

  task automatic test_stop();
    int n = 0;
    @(negedge clk);
    dwell = 4'd2; mode = 1'b0; dir = 1'b0; start = 1'b1; stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (sel !== 3'd3 && n < 40) begin
      total++;
      if ({sel, active, step, done} !== {m.sel, m.run, m.step, m.done}) begin
        bad++; $display("FAIL stop_model n=%0d got sel=%0d act=%b want sel=%0d act=%b", n, sel, active, m.sel, m.run);
      end
      @(negedge clk); n++;
    end
    total++; if (n >= 40) begin bad++; $display("FAIL stop_wait got=timeout want=sel3"); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (active !== 1'b0 || sel !== 3'd3 || done !== 1'b0 || step !== 1'b0) begin
      bad++; $display("FAIL stop_abort got act=%b sel=%0d dn=%b stp=%b want 0 3 0 0", active, sel, done, step);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (sel !== 3'd3 || done !== 1'b0 || active !== 1'b0 || y !== 8'b00001000) begin
        bad++; $display("FAIL stop_idle got sel=%0d dn=%b act=%b y=%b want 3 0 0 00001000", sel, done, active, y);
      end
    end
    start = 1'b1; dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (sel !== 3'd0 || active !== 1'b1) begin bad++; $display("FAIL stop_restart got sel=%0d act=%b want 0 1", sel, active); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_simultaneous();
    int n = 0, ac = 0, dc = 0;
    @(negedge clk);
    dwell = 4'd0; mode = 1'b0; dir = 1'b0; start = 1'b1; stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (sel !== 3'd7 && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL simul_wait got=timeout want=sel7"); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (done !== 1'b0 || active !== 1'b0 || sel !== 3'd7) begin
      bad++; $display("FAIL simul_stop_term got dn=%b act=%b sel=%0d want 0 0 7", done, active, sel);
    end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    total++;
    if (active !== 1'b0 || sel !== 3'd7 || m.run !== 1'b0) begin
      bad++; $display("FAIL simul_start_stop got act=%b sel=%0d want act=0 sel=7", active, sel);
    end
    dwell = 4'd1; dir = 1'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0; dwell = 4'd5;
    for (int c = 0; c < 20; c++) begin
      total++;
      if ({sel, active, step, done} !== {m.sel, m.run, m.step, m.done}) begin
        bad++; $display("FAIL simul_dwell_model c=%0d got sel=%0d act=%b stp=%b dn=%b want sel=%0d act=%b stp=%b dn=%b",
                        c, sel, active, step, done, m.sel, m.run, m.step, m.done);
      end
      if (active) ac++;
      if (done) dc++;
      @(negedge clk);
    end
    total++;
    if (ac != 16 || dc != 1) begin bad++; $display("FAIL simul_dwell_latch got acnt=%0d dones=%0d want 16 1", ac, dc); end
  endtask

  task automatic test_reset_midscan();
    int n = 0, dc = 0;
    @(negedge clk);
    dwell = 4'($urandom_range(0, 3)); mode = 1'($urandom); dir = 1'b0; start = 1'b1; stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (sel !== 3'd5 && n < 40) begin @(negedge clk); n++; end
    total++; if (n >= 40) begin bad++; $display("FAIL rstmid_wait got=timeout want=sel5"); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (sel !== 3'b000 || active !== 1'b0 || done !== 1'b0 || y !== 8'b00000001) begin
      bad++; $display("FAIL rstmid_async got sel=%b act=%b dn=%b y=%b want 000 0 0 00000001", sel, active, done, y);
    end
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dc++;
      total++;
      if (active !== 1'b0 || sel !== 3'd0 || step !== 1'b0) begin
        bad++; $display("FAIL rstmid_idle c=%0d got act=%b sel=%0d stp=%b want 0 0 0", c, active, sel, step);
      end
    end
    total++; if (dc != 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", dc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++;
      if ({sel, active, step, done, y} !== {m.sel, m.run, m.step, m.done, exp_y}) begin
        bad++;
        $display("FAIL random_model c=%0d got sel=%0d act=%b stp=%b dn=%b y=%b want sel=%0d act=%b stp=%b dn=%b y=%b",
                 c, sel, active, step, done, y, m.sel, m.run, m.step, m.done, exp_y);
      end
      start = ($urandom % 4) == 0;
      stop  = ($urandom % 24) == 0;
      mode  = 1'($urandom);
      dir   = 1'($urandom);
      dwell = 4'($urandom_range(0, 3));
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0; dwell = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_oneshot_up();
    test_down_continuous();
    test_stop();
    test_simultaneous();
    test_reset_midscan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
